instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Converts field-level instruction requests into RV32I 32-bit instruction words (R/I/S/B/U/J formats).
- Tags each word with a sequential instruction address and buffers results in a 2-entry output queue with valid/ready on both sides.
- Feeds the instruction-memory loader and test-program generators; its output words are legal decoder input.

Parameters:
- BASE_ADDR, 32'h0000_0000, address assigned to the first word after reset/clear
- ADDR_STEP, 4, address increment per accepted request
- COUNT_W, 16, width of the emitted-word counter

Ports:
- CLK  input  1  clock, rising edge
- reset  input  1  synchronous, active-low reset
- clear  input  1  synchronous flush: empties queue, address to BASE_ADDR, count to 0
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready
- in_fmt  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6..7 illegal
- in_opcode  input  7  opcode field, copied to bits 6:0
- in_rd  input  5  destination register
- in_rs1  input  5  source register 1
- in_rs2  input  5  source register 2
- in_funct3  input  3  funct3
- in_funct7  input  7  funct7 (R only)
- in_imm  input  32  signed immediate / byte offset (U: full 32-bit value)
- out_valid  output  1  queue head valid
- out_ready  input  1  consumer accepts head when out_valid && out_ready
- out_instr  output  32  encoded word
- out_addr  output  32  address of word
- out_err  output  1  word flagged invalid
- count  output  COUNT_W  words popped, saturating

Behaviour:
- Encoding (standard RV32I bit placement):
  - R: funct7|rs2|rs1|f3|rd|op
  - I: imm[11:0]|rs1|f3|rd|op
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op
  - U: imm[31:12]|rd|op
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
  - Fields not used by a format are ignored.
- Illegal in_fmt or in_opcode[1:0]!=2'b11: out_instr=0, out_err=1.
- Encoding is combinational at accept; the entry is written to the 2-entry FIFO the same edge. out_valid rises the next cycle (latency 1).
- in_ready = (occupancy<2) && !clear && reset. It depends only on registered state, never combinationally on out_ready.
- Full queue with a simultaneous pop: no push that cycle; in_ready rises the following cycle.
- Simultaneous push and pop at occupancy 1: occupancy stays 1, order preserved.
- Address counter: the accepted request gets the current address, then the counter adds ADDR_STEP, wrapping modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
- count increments on each pop and saturates at all-ones.
- clear has priority over push/pop that cycle: queue emptied, out_valid=0 next cycle, address=BASE_ADDR, count=0.
- Reset (reset=0 at a clock edge), including mid-transfer:
  - out_valid=0, out_instr=0, out_addr=0, out_err=0, count=0, in_ready=0 while asserted.
  - Address counter = BASE_ADDR; in-flight entries are discarded.
- Output fields hold stable while out_valid && !out_ready.

Optional Feature:
- Macro INSTR_ENC_RANGE_CHECK_EN.
- Defined: out_err is additionally set when any of the following holds:
  - I/S: imm outside [-2048, 2047]
  - B: imm odd or outside [-4096, 4094]
  - J: imm odd or outside [-1048576, 1048574]
  - U: imm[11:0]!=0
  - The word is still encoded with truncated bits.
- Undefined: only illegal fmt/opcode sets out_err; range logic absent.

Test Plan:
- R fmt, op=0x33, rd=3, rs1=1, rs2=2, f3=0, f7=0, out_ready=1 -> out_instr=0x002081B3, out_addr=BASE_ADDR, out_err=0, out_valid one cycle after accept.
- I fmt, op=0x13, rd=1, rs1=0, f3=0, imm=-1 -> 0xFFF00093. B fmt, op=0x63, rs1=1, rs2=2, f3=0, imm=8 -> 0x00208463.
- J fmt, op=0x6F, rd=1, imm=2048 -> 0x001000EF. in_fmt=7 -> out_instr=0, out_err=1.
- out_ready=0, push 3 requests -> in_ready low after 2 accepted, third held. Raise out_ready -> words pop in order with addrs BASE, +4, +8; count=3.
- I fmt imm=2048 -> with INSTR_ENC_RANGE_CHECK_EN out_err=1, imm field 0x800; without it out_err=0.
- Assert clear, then separately reset=0, each with 2 entries queued -> out_valid=0 next cycle, count=0; next request gets out_addr=BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I field-to-word encoder with a 2-entry output queue and sequential address tagging.
// Define INSTR_ENC_RANGE_CHECK_EN to flag immediates that do not fit their format.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ADDR_STEP = 32'd4,
    parameter int unsigned COUNT_W   = 16
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_fmt,
    input  logic [6:0]         in_opcode,
    input  logic [4:0]         in_rd,
    input  logic [4:0]         in_rs1,
    input  logic [4:0]         in_rs2,
    input  logic [2:0]         in_funct3,
    input  logic [6:0]         in_funct7,
    input  logic [31:0]        in_imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic [31:0]        out_addr,
    output logic               out_err,
    output logic [COUNT_W-1:0] count
);

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    logic [31:0]        r_q_instr [2];
    logic [31:0]        r_q_addr  [2];
    logic [1:0]         r_q_err;
    logic               r_wptr;
    logic               r_rptr;
    logic [1:0]         r_occ;
    logic [31:0]        r_addr;
    logic [COUNT_W-1:0] r_count;

    logic [31:0] w_instr;
    logic        w_err;
    logic        w_fmt_ok;
    logic        w_push;
    logic        w_pop;

`ifdef INSTR_ENC_RANGE_CHECK_EN
    logic signed [31:0] w_imm_s;
    logic               w_range_err;

    always_comb begin
        w_imm_s     = $signed(in_imm);
        w_range_err = 1'b0;
        case (in_fmt)
            FMT_I, FMT_S: w_range_err = (w_imm_s < -2048) || (w_imm_s > 2047);
            FMT_B:        w_range_err = in_imm[0] || (w_imm_s < -4096) || (w_imm_s > 4094);
            FMT_J:        w_range_err = in_imm[0] || (w_imm_s < -1048576) || (w_imm_s > 1048574);
            FMT_U:        w_range_err = (in_imm[11:0] != 12'd0);
            default:      w_range_err = 1'b0;
        endcase
    end
`endif

    always_comb begin
        w_instr  = '0;
        w_err    = 1'b0;
        w_fmt_ok = 1'b1;
        case (in_fmt)
            FMT_R: w_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            FMT_I: w_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            FMT_S: w_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            FMT_B: w_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                              in_imm[4:1], in_imm[11], in_opcode};
            FMT_U: w_instr = {in_imm[31:12], in_rd, in_opcode};
            FMT_J: w_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                              in_rd, in_opcode};
            default: w_fmt_ok = 1'b0;
        endcase
        if (!w_fmt_ok || (in_opcode[1:0] != 2'b11)) begin
            w_instr = '0;
            w_err   = 1'b1;
        end
`ifdef INSTR_ENC_RANGE_CHECK_EN
        else if (w_range_err) begin
            w_err = 1'b1;
        end
`endif
    end

    // Readiness looks only at occupancy and the control inputs, never at out_ready.
    assign in_ready  = (r_occ != 2'd2) && !clear && reset;
    assign out_valid = (r_occ != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge CLK) begin
        if (!reset || clear) begin
            r_occ   <= '0;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_addr  <= BASE_ADDR;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_q_instr[r_wptr] <= w_instr;
                r_q_addr[r_wptr]  <= r_addr;
                r_q_err[r_wptr]   <= w_err;
                r_wptr            <= ~r_wptr;
                r_addr            <= r_addr + ADDR_STEP;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
                if (r_count != '1) begin
                    r_count <= r_count + COUNT_W'(1);
                end
            end
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Empty queue presents zeros so reset/clear leave the output fields at 0.
    assign out_instr = out_valid ? r_q_instr[r_rptr] : '0;
    assign out_addr  = out_valid ? r_q_addr[r_rptr]  : '0;
    assign out_err   = out_valid ? r_q_err[r_rptr]   : 1'b0;
    assign count     = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed vectors plus randomized requests.
module tb_instr_encoder;

    localparam logic [31:0] BASE = 32'hFFFF_FFF8;
    localparam logic [31:0] STEP = 32'd4;

    logic        CLK = 1'b0;
    logic        reset, clear, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [2:0]  in_fmt, in_funct3;
    logic [6:0]  in_opcode, in_funct7;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm, out_instr, out_addr;
    logic [15:0] count;

    instr_encoder #(.BASE_ADDR(BASE), .ADDR_STEP(STEP), .COUNT_W(16)) dut (
        .CLK(CLK), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .out_err(out_err), .count(count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_err    = 0;
    int unsigned n_acc    = 0;
    int unsigned m_count  = 0;
    bit          rand_mode = 0;
    exp_t        pend;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder: places fields by shifting/masking the integer values.
    function automatic void ref_enc(input logic [2:0] fmt, input logic [6:0] op,
                                    input logic [4:0] rd, input logic [4:0] rs1,
                                    input logic [4:0] rs2, input logic [2:0] f3,
                                    input logic [6:0] f7, input logic [31:0] imm,
                                    output logic [31:0] w, output logic e);
        longint u, s, acc;
        u = longint'(imm);
        s = longint'($signed(imm));
        acc = 0;
        e = 0;
        case (fmt)
            3'd0: acc = (longint'(f7) << 25) | (longint'(rs2) << 20);
            3'd1: acc = (u & 4095) << 20;
            3'd2: acc = (((u >> 5) & 127) << 25) | (longint'(rs2) << 20) | ((u & 31) << 7);
            3'd3: acc = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (longint'(rs2) << 20)
                      | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7);
            3'd4: acc = u & 64'hFFFF_F000;
            3'd5: acc = (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21)
                      | (((u >> 11) & 1) << 20) | (((u >> 12) & 255) << 12);
            default: acc = 0;
        endcase
        if (fmt <= 3'd3) acc = acc | (longint'(rs1) << 15) | (longint'(f3) << 12);
        if (fmt == 3'd0 || fmt == 3'd1 || fmt >= 3'd4) acc = acc | (longint'(rd) << 7);
        acc = acc | longint'(op);
`ifdef INSTR_ENC_RANGE_CHECK_EN
        case (fmt)
            3'd1, 3'd2: e = (s < -2048) || (s > 2047);
            3'd3: e = (s % 2 != 0) || (s < -4096) || (s > 4094);
            3'd4: e = (u % 4096) != 0;
            3'd5: e = (s % 2 != 0) || (s < -1048576) || (s > 1048574);
            default: e = 0;
        endcase
`endif
        w = 32'(acc);
        if (fmt > 3'd5 || (op % 4) != 3) begin
            w = 0;
            e = 1;
        end
    endfunction

    task automatic present(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] imm,
                           input bit use_exp, input logic [31:0] exp_i, input logic exp_e);
        logic [31:0] w;
        logic e;
        in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
        ref_enc(fmt, op, rd, rs1, rs2, f3, f7, imm, w, e);
        pend.instr = use_exp ? exp_i : w;
        pend.err   = use_exp ? exp_e : e;
    endtask

    task automatic wait_accept();
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (in_ready) begin
                pend.addr = BASE + STEP * n_acc;
                n_acc++;
                sb.push_back(pend);
                @(posedge CLK); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge CLK); #1;
            if (rand_mode) out_ready = 1'($urandom_range(0, 1));
        end
        chk("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm,
                        input bit use_exp, input logic [31:0] exp_i, input logic exp_e);
        present(fmt, op, rd, rs1, rs2, f3, f7, imm, use_exp, exp_i, exp_e);
        wait_accept();
    endtask

    task automatic drain();
        int i;
        out_ready = 1'b1;
        for (i = 0; i < 50; i++) begin
            @(negedge CLK); #2;
            if (sb.size() == 0) break;
        end
        if (i == 50) chk("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge CLK); #1;
    endtask

    // Monitor: flushes on reset/clear, otherwise checks count and every popped word.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK); #1;
            if (!reset || clear) begin
                sb.delete();
                m_count = 0;
            end else begin
                chk("count", 32'(count), m_count);
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_pop", out_instr, 32'hDEAD_0000);
                    end else begin
                        e = sb.pop_front();
                        chk("out_instr", out_instr, e.instr);
                        chk("out_addr", out_addr, e.addr);
                        chk("out_err", 32'(out_err), 32'(e.err));
                        if (m_count < 65535) m_count++;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] imm;
        logic [6:0]  op;
        reset = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_addr", out_addr, 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge CLK); #1;
        reset = 1'b1;

        send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1, 32'h0020_81B3, 1'b0);
        @(negedge CLK);
        chk("latency_out_valid", 32'(out_valid), 32'd1);
        @(posedge CLK); #1;
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1, 32'hFFF0_0093, 1'b0);
        send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 1, 32'h0020_8463, 1'b0);
        send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1, 32'h0010_00EF, 1'b0);
        send(3'd7, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1, 32'h0000_0000, 1'b1);
`ifdef INSTR_ENC_RANGE_CHECK_EN
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1, 32'h8000_0093, 1'b1);
`else
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1, 32'h8000_0093, 1'b0);
`endif
        drain();

        // Backpressure: third request held until the consumer drains; addresses wrap past 2^32.
        clear = 1'b1; n_acc = 0;
        @(posedge CLK); #1;
        clear = 1'b0; out_ready = 1'b0;
        send(3'd0, 7'h33, 5'd5, 5'd6, 5'd7, 3'd1, 7'h20, 32'd0, 0, 32'd0, 1'b0);
        send(3'd2, 7'h23, 5'd0, 5'd2, 5'd9, 3'd2, 7'd0, 32'hFFFF_FFF4, 0, 32'd0, 1'b0);
        present(3'd4, 7'h37, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 0, 32'd0, 1'b0);
        @(negedge CLK);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        @(posedge CLK); #1;
        out_ready = 1'b1;
        wait_accept();
        drain();
        chk("count_after_3", 32'(count), 32'd3);

        // Clear with two entries queued.
        out_ready = 1'b0;
        send(3'd1, 7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'd5, 0, 32'd0, 1'b0);
        send(3'd1, 7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'd6, 0, 32'd0, 1'b0);
        clear = 1'b1; n_acc = 0;
        @(negedge CLK);
        chk("clear_in_ready", 32'(in_ready), 32'd0);
        @(posedge CLK); #1;
        clear = 1'b0;
        @(negedge CLK);
        chk("clear_out_valid", 32'(out_valid), 32'd0);
        chk("clear_count", 32'(count), 32'd0);
        @(posedge CLK); #1;
        out_ready = 1'b1;
        send(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd4, 7'd0, 32'd0, 0, 32'd0, 1'b0);
        drain();

        // Reset mid-transfer with two entries queued.
        out_ready = 1'b0;
        send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFF0, 0, 32'd0, 1'b0);
        send(3'd3, 7'h63, 5'd0, 5'd4, 5'd5, 3'd1, 7'd0, 32'hFFFF_F000, 0, 32'd0, 1'b0);
        reset = 1'b0; n_acc = 0;
        @(negedge CLK);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        @(posedge CLK); #1;
        reset = 1'b1;
        @(negedge CLK);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_count", 32'(count), 32'd0);
        @(posedge CLK); #1;
        out_ready = 1'b1;
        send(3'd1, 7'h03, 5'd7, 5'd8, 5'd0, 3'd2, 7'd0, 32'd12, 0, 32'd0, 1'b0);
        drain();

        rand_mode = 1;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0: imm = $urandom;
                1: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                2: imm = (32'($urandom_range(0, 8191)) - 32'd4096) & 32'hFFFF_FFFE;
                default: imm = $urandom & 32'hFFFF_F000;
            endcase
            op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : {5'($urandom), 2'b11};
            out_ready = 1'($urandom_range(0, 1));
            send(3'($urandom), op, 5'($urandom), 5'($urandom), 5'($urandom),
                 3'($urandom), 7'($urandom), imm, 0, 32'd0, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge CLK); #1;
            end
        end
        rand_mode = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
